uart_rx_in: RTL and testbench

- Serial 8N1 UART receiver. It is the input-direction counterpart of the CPU's 9-bit {valid, data} character output path.
- Deserialises an asynchronous rx line into bytes and buffers them in a small FIFO.
- Presents the FIFO head to the RV32IM core as a 9-bit {valid, data} word, the same packing as uart_out. The core consumes the head with a one-cycle read strobe.
- Used in the testbench and on FPGA for console input.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 57 +++++
 rtl/uart_rx_in.sv | 147 ++++++++++++++
 tb/tb_uart_rx_in.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned UART_DATA_BITS = 8;

    // 9-bit uart word: {valid, data}
    localparam int unsigned VALID_BIT = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes; head is zero when empty.
module uart_rx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents only matter once written, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_in.sv
// 8N1 UART receiver feeding a FIFO, presented as a 9-bit {valid, data} word.
module uart_rx_in
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       rd,
    input  logic       clr,
    output logic [8:0] uart_in,
    output logic       overrun,
    output logic       frame_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    rx_state_t                   state;
    rx_state_t                   state_next;
    logic                        rx_meta;
    logic                        rxs;
    logic [CW-1:0]               sample_cnt;
    logic [2:0]                  bit_idx;
    logic [UART_DATA_BITS-1:0]   shift;
    logic                        tick;
    logic                        push;
    logic                        frame_set;
    logic [UART_DATA_BITS-1:0]   fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_drop;

    assign tick = (sample_cnt == '0);

    // Two-flop synchroniser for the asynchronous rx line (idles high).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Receive FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Receive FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rxs) state_next = START;
            START: if (tick) state_next = rxs ? IDLE : DATA;
            DATA:  if (tick && bit_idx == LAST_BIT) state_next = STOP;
            STOP:  if (tick) state_next = rxs ? IDLE : BREAK;
            BREAK: if (rxs)  state_next = IDLE;
            default:         state_next = IDLE;
        endcase
    end

    // Receive FSM outputs: byte push on a good stop bit, frame error on a bad one.
    always_comb begin
        push      = 1'b0;
        frame_set = 1'b0;
        if (state == STOP && tick) begin
            push      = rxs;
            frame_set = !rxs;
        end
    end

    // Bit-timing counters and shift register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample_cnt <= '0;
            bit_idx    <= '0;
            shift      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) sample_cnt <= HALF_LOAD;
                end
                START: begin
                    if (tick) begin
                        sample_cnt <= FULL_LOAD;
                        bit_idx    <= '0;
                    end else begin
                        sample_cnt <= sample_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift[bit_idx] <= rxs;
                        bit_idx        <= bit_idx + 1'b1;
                        sample_cnt     <= FULL_LOAD;
                    end else begin
                        sample_cnt <= sample_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (!tick) sample_cnt <= sample_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sticky error flags; a set event in the same cycle as clr wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (fifo_drop)   overrun <= 1'b1;
            else if (clr)    overrun <= 1'b0;
            if (frame_set)   frame_err <= 1'b1;
            else if (clr)    frame_err <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (UART_DATA_BITS)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (shift),
        .pop       (rd),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign uart_in[VALID_BIT]   = !fifo_empty;
    assign uart_in[VALID_BIT-1:0] = fifo_head;

endmodule

// File: tb/tb_uart_rx_in.sv
// Directed self-checking bench for uart_rx_in (16 clocks/bit, 4-deep FIFO).
module tb_uart_rx_in;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       rd;
    logic       clr;
    logic [8:0] uart_in;
    logic       overrun;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    uart_rx_in #(
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx        (rx),
        .rd        (rd),
        .clr       (clr),
        .uart_in   (uart_in),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives one frame cycle by cycle; reports the edge count (from the start
    // edge) at which uart_in[8] first rose, and can hold rd high at one edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_level,
                              input int stop_cycles, input int rd_edge,
                              output int rise_at);
        int   total;
        logic prev;
        total   = 144 + stop_cycles;
        rise_at = -1;
        prev    = uart_in[8];
        for (int k = 0; k < total; k++) begin
            if (k < 16)       rx = 1'b0;
            else if (k < 144) rx = b[(k - 16) / 16];
            else              rx = stop_level;
            rd = (rd_edge > 0 && k == rd_edge - 1);
            @(posedge clock);
            #1;
            if (uart_in[8] && !prev && rise_at < 0) rise_at = k + 1;
            prev = uart_in[8];
        end
        rx = 1'b1;
        rd = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [8:0] exp);
        check(tag, uart_in, exp);
        rd = 1'b1;
        @(posedge clock);
        #1;
        rd = 1'b0;
    endtask

    task automatic pulse_clr;
        clr = 1'b1;
        @(posedge clock);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        int r;
        rx      = 1'b1;
        rd      = 1'b0;
        clr     = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_uart_in", uart_in, 9'h000);
        check("reset_overrun", 9'(overrun), 9'h000);
        check("reset_frame_err", 9'(frame_err), 9'h000);
        reset_n = 1'b1;
        idle(5);

        // Single byte 'A' with latency window
        send_frame(8'h41, 1'b1, 16, -1, r);
        check("latency_A_in_window", 9'((r >= 152) && (r <= 156)), 9'h001);
        idle(4);
        check("rx_A", uart_in, 9'h141);
        pop_check("pop_A", 9'h141);
        check("empty_after_A", uart_in, 9'h000);
        check("no_overrun_A", 9'(overrun), 9'h000);
        check("no_frame_err_A", 9'(frame_err), 9'h000);

        // Short low glitch is a false start
        rx = 1'b0;
        idle(6);
        rx = 1'b1;
        idle(40);
        check("glitch_no_push", uart_in, 9'h000);
        check("glitch_no_frame_err", 9'(frame_err), 9'h000);
        send_frame(8'h5A, 1'b1, 16, -1, r);
        idle(4);
        check("rx_5A", uart_in, 9'h15A);
        pop_check("pop_5A", 9'h15A);

        // Stop bit held low: frame error, byte discarded, then recovery
        send_frame(8'h33, 1'b0, 32, -1, r);
        idle(20);
        check("frame_err_set", 9'(frame_err), 9'h001);
        check("frame_err_fifo_empty", uart_in, 9'h000);
        send_frame(8'h34, 1'b1, 16, -1, r);
        idle(4);
        check("rx_34", uart_in, 9'h134);
        check("frame_err_still_set", 9'(frame_err), 9'h001);
        pulse_clr();
        check("frame_err_cleared", 9'(frame_err), 9'h000);
        pop_check("pop_34", 9'h134);

        // Five back-to-back bytes overflow a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 16, -1, r);
        idle(4);
        check("overrun_set", 9'(overrun), 9'h001);
        pop_check("ovr_pop1", 9'h101);
        pop_check("ovr_pop2", 9'h102);
        pop_check("ovr_pop3", 9'h103);
        pop_check("ovr_pop4", 9'h104);
        check("ovr_empty", uart_in, 9'h000);
        pulse_clr();
        check("overrun_cleared", 9'(overrun), 9'h000);

        // Pop coincident with the push into a full FIFO
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 16, -1, r);
        idle(2);
        check("full_head_01", uart_in, 9'h101);
        send_frame(8'h05, 1'b1, 16, 155, r);
        idle(4);
        check("simul_no_overrun", 9'(overrun), 9'h000);
        pop_check("simul_pop1", 9'h102);
        pop_check("simul_pop2", 9'h103);
        pop_check("simul_pop3", 9'h104);
        pop_check("simul_pop4", 9'h105);
        check("simul_empty", uart_in, 9'h000);

        // Reset in the middle of a frame
        send_frame(8'h11, 1'b1, 16, -1, r);
        idle(4);
        check("pre_reset_byte", uart_in, 9'h111);
        rx = 1'b0;
        idle(88);
        reset_n = 1'b0;
        #1;
        check("midreset_uart_in", uart_in, 9'h000);
        check("midreset_overrun", 9'(overrun), 9'h000);
        check("midreset_frame_err", 9'(frame_err), 9'h000);
        idle(3);
        rx = 1'b1;
        idle(2);
        reset_n = 1'b1;
        idle(20);
        check("post_reset_empty", uart_in, 9'h000);
        send_frame(8'h7E, 1'b1, 16, -1, r);
        idle(10);
        check("rx_7E", uart_in, 9'h17E);
        pop_check("pop_7E", 9'h17E);
        check("only_7E", uart_in, 9'h000);
        check("final_frame_err", 9'(frame_err), 9'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
